// File: rtl/cp0_if.sv
// Pipeline-side signal bundle for the CP0 exception/interrupt controller.
// master = pipeline (M stage + fetch), slave = cp0.
interface cp0_if;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_in;
    logic [31:0] badvaddr_in;
    logic        eret;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output en, cp0_addr, cp0_in, vpc, bd_in, exc_in, badvaddr_in, eret, hw_int,
        input  cp0_out, req, epc_out
    );

    modport slave (
        input  en, cp0_addr, cp0_in, vpc, bd_in, exc_in, badvaddr_in, eret, hw_int,
        output cp0_out, req, epc_out
    );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC, interrupt/exception redirect request, mtc0/mfc0, eret target.
// Optional BadVAddr register (reg 8) enabled by defining CP0_BADVADDR_EN.
module cp0 (
    input  logic   clk,
    input  logic   rst,
    cp0_if.slave   bus
);
    localparam logic [31:0] PRID = 32'h4348_5030;

    logic [5:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic [5:0]  ip_reg;
    logic [4:0]  exc_code_reg;
    logic [31:0] epc_reg;
    logic [31:0] badvaddr_rd;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim_pc;

    // Interrupts use the raw lines, not the registered IP copy.
    assign int_req   = (|(bus.hw_int & im_reg)) & ie_reg & ~exl_reg;
    assign exc_req   = (bus.exc_in != 5'd0) & ~exl_reg;
    assign bus.req   = ~rst & (int_req | exc_req);
    assign victim_pc = bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
    assign bus.epc_out = epc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            im_reg       <= '0;
            exl_reg      <= 1'b0;
            ie_reg       <= 1'b0;
            bd_reg       <= 1'b0;
            ip_reg       <= '0;
            exc_code_reg <= '0;
            epc_reg      <= '0;
        end else begin
            ip_reg <= bus.hw_int;
            if (bus.req) begin
                exl_reg      <= 1'b1;
                exc_code_reg <= int_req ? 5'd0 : bus.exc_in;
                bd_reg       <= bus.bd_in;
                epc_reg      <= {victim_pc[31:2], 2'b00};
            end else if (bus.eret) begin
                exl_reg <= 1'b0;
            end else if (bus.en) begin
                case (bus.cp0_addr)
                    5'd12: begin
                        im_reg  <= bus.cp0_in[15:10];
                        exl_reg <= bus.cp0_in[1];
                        ie_reg  <= bus.cp0_in[0];
                    end
                    5'd14:   epc_reg <= {bus.cp0_in[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_reg;
    logic        fetch_fault;

    // A misaligned or out-of-text-range PC means the fetch itself faulted.
    assign fetch_fault = (bus.vpc[1:0] != 2'b00) || (bus.vpc < 32'h0000_3000) ||
                         (bus.vpc > 32'h0000_6ffc);

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_reg <= '0;
        end else if (bus.req && !int_req &&
                     (bus.exc_in == 5'd4 || bus.exc_in == 5'd5)) begin
            badvaddr_reg <= fetch_fault ? bus.vpc : bus.badvaddr_in;
        end
    end

    assign badvaddr_rd = badvaddr_reg;
`else
    logic unused_badvaddr;
    assign unused_badvaddr = ^bus.badvaddr_in;
    assign badvaddr_rd     = '0;
`endif

    always_comb begin
        bus.cp0_out = '0;
        case (bus.cp0_addr)
            5'd8:  bus.cp0_out = badvaddr_rd;
            5'd12: bus.cp0_out = {16'b0, im_reg, 8'b0, exl_reg, ie_reg};
            5'd13: bus.cp0_out = {bd_reg, 15'b0, ip_reg, 3'b0, exc_code_reg, 2'b00};
            5'd14: bus.cp0_out = epc_reg;
            5'd15: bus.cp0_out = PRID;
            default: bus.cp0_out = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: a register-image model is compared every cycle, plus literal checks.
module tb_cp0;
    logic clk = 1'b0;
    logic rst;
    cp0_if bus ();

    cp0 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural register images as software would see them.
    logic [31:0] m_sr, m_cause, m_epc, m_badv;

    function automatic logic m_int();
        return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        if (rst) return 1'b0;
        return m_int() || ((bus.exc_in != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
`ifdef CP0_BADVADDR_EN
            5'd8:  return m_badv;
`endif
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h4348_5030;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] sr, cause, epc, badv, pc;
        logic [4:0]  code;
        sr = m_sr; cause = m_cause; epc = m_epc; badv = m_badv;
        if (rst) begin
            sr = 0; cause = 0; epc = 0; badv = 0;
        end else begin
            cause = (cause & ~32'h0000_FC00) | (32'(bus.hw_int) << 10);
            if (m_req()) begin
                code  = m_int() ? 5'd0 : bus.exc_in;
                sr    = sr | 32'h2;
                cause = (cause & 32'h0000_FC00) | (32'(bus.bd_in) << 31) | (32'(code) << 2);
                pc    = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
                epc   = pc & ~32'h3;
                if (code == 5'd4 || code == 5'd5) begin
                    if (bus.vpc % 4 != 0 || bus.vpc < 32'h3000 || bus.vpc > 32'h6ffc)
                        badv = bus.vpc;
                    else
                        badv = bus.badvaddr_in;
                end
            end else if (bus.eret) begin
                sr = sr & ~32'h2;
            end else if (bus.en) begin
                if (bus.cp0_addr == 5'd12) sr  = bus.cp0_in & 32'h0000_FC03;
                if (bus.cp0_addr == 5'd14) epc = bus.cp0_in & ~32'h3;
            end
        end
        m_sr <= sr; m_cause <= cause; m_epc <= epc; m_badv <= badv;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One cycle: model compare away from the edge, then step past the next posedge.
    task automatic cyc();
        @(negedge clk);
        chk("model req", 32'(bus.req), 32'(m_req()));
        chk("model cp0_out", bus.cp0_out, m_read(bus.cp0_addr));
        chk("model epc_out", bus.epc_out, m_epc);
        $display("cycle t=%0t addr=%0d out=0x%08h req=%0b epc=0x%08h",
                 $time, bus.cp0_addr, bus.cp0_out, bus.req, bus.epc_out);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_addr = a;
        #1;
        chk(name, bus.cp0_out, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.en = 1'b1; bus.cp0_addr = a; bus.cp0_in = d;
        cyc();
        bus.en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 0; bus.cp0_addr = 0; bus.cp0_in = 0; bus.vpc = 0; bus.bd_in = 0;
        bus.exc_in = 0; bus.badvaddr_in = 0; bus.eret = 0; bus.hw_int = 0;
        @(posedge clk); #1;

        // Reset state
        rd("reset SR", 5'd12, 32'h0);
        rd("reset Cause", 5'd13, 32'h0);
        rd("reset EPC", 5'd14, 32'h0);
        chk("reset req", 32'(bus.req), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();

        // Exception in a delay slot
        mtc0(5'd12, 32'h0000_FC01);
        rd("SR after mtc0", 5'd12, 32'h0000_FC01);
        bus.exc_in = 5'd10; bus.bd_in = 1'b1; bus.vpc = 32'h3010;
        #1; chk("exc req same cycle", 32'(bus.req), 32'h1);
        cyc();
        bus.exc_in = 0; bus.bd_in = 0;
        rd("EPC delay slot", 5'd14, 32'h0000_300C);
        rd("Cause delay slot", 5'd13, 32'h8000_0028);
        rd("SR EXL set", 5'd12, 32'h0000_FC03);
        chk("req low after EXL", 32'(bus.req), 32'h0);
        bus.exc_in = 5'd3; #1;
        chk("nested exc masked", 32'(bus.req), 32'h0);
        cyc();
        bus.exc_in = 0;
        rd("Cause unchanged by nested", 5'd13, 32'h8000_0028);
        bus.eret = 1'b1; cyc(); bus.eret = 0;
        rd("SR after eret", 5'd12, 32'h0000_FC01);
        chk("epc_out", bus.epc_out, 32'h0000_300C);

        // Interrupt beats exception; eret then re-entry
        mtc0(5'd12, 32'h0000_1001);
        bus.hw_int = 6'b000100; bus.exc_in = 5'd12; bus.vpc = 32'h3020;
        #1; chk("int req", 32'(bus.req), 32'h1);
        cyc();
        bus.exc_in = 0;
        rd("Cause int wins", 5'd13, 32'h0000_1000);
        rd("EPC int", 5'd14, 32'h0000_3020);
        bus.eret = 1'b1; #1;
        chk("req masked during eret", 32'(bus.req), 32'h0);
        cyc();
        bus.eret = 0;
        rd("SR after int eret", 5'd12, 32'h0000_1001);
        chk("req reasserts", 32'(bus.req), 32'h1);
        cyc();
        bus.hw_int = 0; bus.eret = 1'b1; cyc(); bus.eret = 0;

        // Masking
        mtc0(5'd12, 32'h0000_1000);
        bus.hw_int = 6'b000100; #1;
        chk("IE=0 masks", 32'(bus.req), 32'h0);
        cyc();
        rd("IP follows hw_int", 5'd13, 32'h0000_1000);
        mtc0(5'd12, 32'h0000_0801);
        #1; chk("IM clear masks", 32'(bus.req), 32'h0);
        bus.hw_int = 0;
        cyc();

        // mtc0 semantics
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd("SR write mask", 5'd12, 32'h0000_FC03);
        mtc0(5'd12, 32'h0);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("Cause read-only", 5'd13, 32'h0);
        mtc0(5'd14, 32'h0000_3007);
        rd("EPC align", 5'd14, 32'h0000_3004);
        rd("PRId", 5'd15, 32'h4348_5030);

        // mtc0 dropped under req and under eret
        bus.exc_in = 5'd8; bus.vpc = 32'h3100;
        bus.en = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'h5000;
        #1; chk("req with mtc0", 32'(bus.req), 32'h1);
        cyc();
        bus.en = 0; bus.exc_in = 0;
        rd("mtc0 dropped on req", 5'd14, 32'h0000_3100);
        bus.eret = 1'b1; bus.en = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_in = 32'h1;
        cyc();
        bus.eret = 0; bus.en = 0;
        rd("mtc0 dropped on eret", 5'd12, 32'h0);

        // BadVAddr
        bus.exc_in = 5'd4; bus.vpc = 32'h3002; bus.badvaddr_in = 32'h1234;
        cyc();
        bus.exc_in = 0;
`ifdef CP0_BADVADDR_EN
        rd("BadVAddr fetch", 5'd8, 32'h0000_3002);
`else
        rd("BadVAddr absent", 5'd8, 32'h0);
`endif
        rd("EPC misaligned vpc", 5'd14, 32'h0000_3000);
        bus.eret = 1'b1; cyc(); bus.eret = 0;
        bus.exc_in = 5'd5; bus.vpc = 32'h3400; bus.badvaddr_in = 32'h7F01;
        cyc();
        bus.exc_in = 0;
`ifdef CP0_BADVADDR_EN
        rd("BadVAddr data", 5'd8, 32'h0000_7F01);
`else
        rd("BadVAddr absent 2", 5'd8, 32'h0);
`endif
        cyc();

        // Reset mid-handler overrides a pending request
        bus.eret = 1'b1; cyc(); bus.eret = 0;
        bus.exc_in = 5'd6; rst = 1'b1; #1;
        chk("rst blocks req", 32'(bus.req), 32'h0);
        cyc();
        rst = 1'b0; bus.exc_in = 0;
        rd("SR after rst", 5'd12, 32'h0);
        rd("EPC after rst", 5'd14, 32'h0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
